mux_n_hs_reg: RTL

//  Parametrised N-input, W-bit selector with a registered output and a valid/ready handshake.

---
 rtl/mux_n_hs_reg.sv | 110 +++++++++++
 1 files changed

// File: rtl/mux_n_hs_reg.sv
// N-input, W-bit registered selector with valid/ready handshake.
// Channels are chosen by a fixed index (mode 0) or round-robin arbitration (mode 1).
module mux_n_hs_reg #(
    parameter int unsigned           WIDTH       = 32,
    parameter int unsigned           N_IN        = 7,
    parameter int unsigned           SEL_W       = 3,
    parameter logic [WIDTH-1:0]      DEFAULT_VAL = '0
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [N_IN*WIDTH-1:0]    in_bus,
    input  logic [N_IN-1:0]          in_valid,
    output logic [N_IN-1:0]          in_ready,
    input  logic [SEL_W-1:0]         seletor,
    input  logic                     mode,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     sel_err,
    output logic [SEL_W-1:0]         grant_idx
);

    localparam int unsigned LAST_CH = N_IN - 1;

    logic [SEL_W-1:0] ptr;
    logic             sel_ok;
    logic             load_en;
    logic             take;
    logic             fix_vld;
    logic [SEL_W-1:0] fix_idx;
    logic             rr_vld;
    logic [SEL_W-1:0] rr_idx;
    logic             chosen_vld;
    logic [SEL_W-1:0] chosen;
    logic [WIDTH-1:0] chosen_data;

    // Modulo-N_IN wrap for a scan position that is at most 2*N_IN-1.
    function automatic int unsigned wrap_idx(input int unsigned v);
        return (v >= N_IN) ? (v - N_IN) : v;
    endfunction

    assign sel_ok  = 32'(seletor) < N_IN;
    assign load_en = !out_valid || out_ready;

    // Fixed-select candidate: only a valid, in-range channel qualifies.
    always_comb begin
        fix_vld = 1'b0;
        fix_idx = '0;
        for (int unsigned i = 0; i < N_IN; i++) begin
            if (sel_ok && (seletor == SEL_W'(i)) && in_valid[i]) begin
                fix_vld = 1'b1;
                fix_idx = SEL_W'(i);
            end
        end
    end

    // Round-robin candidate: first valid channel scanning from ptr+1 upward.
    always_comb begin
        rr_vld = 1'b0;
        rr_idx = '0;
        for (int unsigned k = 1; k <= N_IN; k++) begin
            for (int unsigned i = 0; i < N_IN; i++) begin
                if (!rr_vld && (i == wrap_idx(32'(ptr) + k)) && in_valid[i]) begin
                    rr_vld = 1'b1;
                    rr_idx = SEL_W'(i);
                end
            end
        end
    end

    assign chosen_vld = mode ? rr_vld : fix_vld;
    assign chosen     = mode ? rr_idx : fix_idx;
    assign take       = reset_n && load_en && chosen_vld;

    // One-hot accept strobe and data mux for the chosen channel.
    always_comb begin
        in_ready    = '0;
        chosen_data = '0;
        for (int unsigned i = 0; i < N_IN; i++) begin
            if (chosen == SEL_W'(i)) begin
                in_ready[i] = take;
                chosen_data = in_bus[i*WIDTH +: WIDTH];
            end
        end
    end

    // Output slot, error flag and arbitration pointer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_data  <= DEFAULT_VAL;
            out_valid <= 1'b0;
            sel_err   <= 1'b0;
            grant_idx <= '0;
            ptr       <= SEL_W'(LAST_CH);
        end else begin
            sel_err <= !mode && !sel_ok;
            if (take) begin
                out_data  <= chosen_data;
                grant_idx <= chosen;
                out_valid <= 1'b1;
                if (mode) begin
                    ptr <= chosen;
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
